// File: rtl/input_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// input_debouncer_pkg
// Shared definitions for the button/switch debouncer:
//   db_state_t        - per-channel debounce FSM state
//   DEF_*             - default timing constants (100 MHz system clock)
//   state_is_high()   - debounced level implied by an FSM state
// -----------------------------------------------------------------------------
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_DEBOUNCE_CYC  = 1_000_000;   // 10 ms at 100 MHz
    localparam int DEF_REPEAT_DELAY  = 50_000_000;  // 500 ms at 100 MHz
    localparam int DEF_REPEAT_PERIOD = 10_000_000;  // 100 ms at 100 MHz

    // The accepted level stays high while a falling edge is still being
    // qualified, and stays low while a rising edge is being qualified.
    function automatic logic state_is_high(input db_state_t st);
        return (st == HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced input: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, registered level/press/release outputs.
// Optional auto-repeat of press while held, enabled by defining BTN_REPEAT_EN.
//
// Ports:
//   clk_i      - system clock, rising edge
//   rst_i      - asynchronous active-high reset
//   raw_i      - asynchronous, bouncy input
//   level_o    - debounced level (registered)
//   press_o    - one-cycle pulse on accepted 0->1 (and on auto-repeat)
//   release_o  - one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYC must be 2 or more");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be 1 or more");
    end

    logic             sync1_q;
    logic             s_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_fire;

    // State register: synchronizer, FSM, counter and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            state_q   <= LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            s_q       <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state logic. cnt counts consecutive samples at the new level; the
    // entering sample already counts as 1, so the change is accepted on the
    // DEBOUNCE_CYC-th consecutive sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LO: begin
                if (s_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!s_q) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (!s_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (s_q) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that the pulses line up
    // with the cycle in which level changes.
    always_comb begin
        level_d   = state_is_high(state_d);
        press_d   = (!state_is_high(state_q) && level_d) || rpt_fire;
        release_d = state_is_high(state_q) && !level_d;
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_phase_q, rpt_phase_d;  // 0: waiting for first repeat
    logic             rpt_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end

    // Counts only while the level stays high across the edge; the entering
    // edge and the leaving edge both clear it, so a release never repeats.
    always_comb begin
        rpt_d       = '0;
        rpt_phase_d = 1'b0;
        rpt_fire    = 1'b0;
        rpt_hit     = rpt_phase_q ? (rpt_q == RPT_W'(REPEAT_PERIOD - 1))
                                  : (rpt_q == RPT_W'(REPEAT_DELAY - 1));
        if (state_is_high(state_q) && state_is_high(state_d)) begin
            rpt_phase_d = rpt_phase_q;
            if (rpt_hit) begin
                rpt_fire    = 1'b1;
                rpt_d       = '0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// N_CH independent debounced board inputs (buttons/switches).
// Define BTN_REPEAT_EN to enable auto-repeat press pulses while held.
//
// Ports:
//   CLOCK_100  - 100 MHz system clock, rising edge
//   reset      - asynchronous active-high reset
//   raw        - [N_CH] asynchronous bouncy inputs
//   level      - [N_CH] debounced registered levels
//   press      - [N_CH] one-cycle pulse on accepted 0->1 (and auto-repeat)
//   release_p  - [N_CH] one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            CLOCK_100,
    input  logic            reset,
    input  logic [N_CH-1:0] raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk_i    (CLOCK_100),
            .rst_i    (reset),
            .raw_i    (raw[ch]),
            .level_o  (level[ch]),
            .press_o  (press[ch]),
            .release_o(release_p[ch])
        );
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
- REQ-001: Parameter N_CH, default 4, number of independent input channels (board buttons).
- REQ-002: Parameter DEBOUNCE_CYC, default 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range is 2 or more.
- REQ-003: Parameter REPEAT_DELAY, default 50_000_000, held cycles before the first auto-repeat press (used only with REQ-024).
- REQ-004: Parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat presses (used only with REQ-024).
- REQ-005: Port CLOCK_100, input, 1, the single 100 MHz system clock; all state is rising-edge triggered.
- REQ-006: Port reset, input, 1, asynchronous, active-high reset.
- REQ-007: Port raw, input, N_CH, asynchronous, bouncy board inputs (BTN/SW).
- REQ-008: Port level, output, N_CH, debounced, registered input level.
- REQ-009: Port press, output, N_CH, one-cycle pulse on an accepted 0->1 transition (and on auto-repeat).
- REQ-010: Port release_p, output, N_CH, one-cycle pulse on an accepted 1->0 transition.

Function
- REQ-011: Each channel SHALL pass raw through a 2-flop synchronizer; the second flop output is s.
- REQ-012: Each channel SHALL run a 4-state FSM {LO, WAIT_HI, HI, WAIT_LO} with a counter of width $clog2(DEBOUNCE_CYC+1).
- REQ-013: In LO, s=1 SHALL move the FSM to WAIT_HI with cnt=1; in HI, s=0 SHALL move it to WAIT_LO with cnt=1.
- REQ-014: In WAIT_HI, s=0 SHALL return the FSM to LO and clear cnt; otherwise, when cnt==DEBOUNCE_CYC-1, it SHALL move to HI; otherwise cnt SHALL increment. WAIT_LO SHALL behave symmetrically.
- REQ-015: level SHALL be 1 in HI and WAIT_LO, and 0 in LO and WAIT_HI, registered.
- REQ-016: Latency: a stable change first sampled by the synchronizer at edge 0 SHALL appear on level after edge DEBOUNCE_CYC+1.
- REQ-017: press or release_p SHALL be asserted for exactly one cycle, in the same cycle level changes.
- REQ-018: Any bounce shorter than DEBOUNCE_CYC stable cycles SHALL produce no level change and no pulse.
- REQ-019: Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
- REQ-020: press and release_p SHALL never both be asserted on one channel in the same cycle.

Reset
- REQ-021: reset SHALL asynchronously clear the synchronizers, FSMs (to LO), counters, and all outputs to 0.
- REQ-022: Reset mid-debounce SHALL abandon the count with no pulse.
- REQ-023: An input held high through reset deassertion SHALL be debounced afresh and produce one press DEBOUNCE_CYC+1 edges after the first sampling edge.

Configuration
- REQ-024: With BTN_REPEAT_EN defined, a channel in HI SHALL count held cycles, emit press (no release_p) after REPEAT_DELAY cycles, then emit press every REPEAT_PERIOD cycles while it stays in HI or WAIT_LO; the repeat counter SHALL clear on leaving HI/WAIT_LO.
- REQ-025: Without BTN_REPEAT_EN, no repeat counter SHALL exist and press SHALL fire only on accepted 0->1 transitions.

Structure
- REQ-026: Package input_debouncer_pkg SHALL hold the FSM state enum (db_state_t) and the default timing constants.
- REQ-027: Sub-module debounce_channel (one synchronizer, FSM, counter, optional repeat) SHALL be instantiated N_CH times via generate.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- REQ-028: raw[0] 0->1 held, sampled at edge 0 -> level[0]=1 and press[0]=1 for one cycle after edge 5; other channels stay 0.
- REQ-029: raw[1] toggles 1,0,1,1,0 every cycle, then stays 0 -> level[1] stays 0; no press or release_p pulse.
- REQ-030: Channel 2 at level 1, raw[2] drops and holds 0 -> release_p[2] pulses once; level[2]=0 five edges after sampling.
- REQ-031: reset asserted mid-count (cnt=2) with raw[3]=1 held, then released -> all outputs 0 immediately; one press[3] five edges after the first post-reset sampling edge.
- REQ-032: raw[0] and raw[3] rise on the same edge -> press[0] and press[3] pulse in the same cycle.
- REQ-033: With BTN_REPEAT_EN defined, hold raw[0] -> initial press, then press 10 cycles after entering HI, then every 3 cycles; no press after release.
